// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one main-memory port between the I-cache and D-cache.
// Define CACHE_ARB_RR_EN for round-robin tie-breaking; otherwise the D-cache wins ties.
module cache_mem_arbiter (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] i_a,
  input  logic        i_strobe,
  output logic [31:0] i_din,
  output logic        i_ready,
  input  logic [31:0] d_a,
  input  logic [31:0] d_dout,
  input  logic        d_rw,
  input  logic        d_strobe,
  output logic [31:0] d_din,
  output logic        d_ready,
  output logic [31:0] m_a,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout,
  output logic        m_rw,
  output logic        m_strobe,
  input  logic        m_ready,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } state_t;

  state_t state;
  logic   lg;
  logic   tie_to_d;
  logic   serve_i;
  logic   serve_d;

`ifdef CACHE_ARB_RR_EN
  // The requester that was not served last wins a tie, so neither starves.
  assign tie_to_d = ~lg;
`else
  logic lg_unused;
  assign lg_unused = lg;
  assign tie_to_d  = 1'b1;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      lg    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_strobe && d_strobe)
            state <= tie_to_d ? SERVE_D : SERVE_I;
          else if (d_strobe)
            state <= SERVE_D;
          else if (i_strobe)
            state <= SERVE_I;
        end
        // The grant is held until memory completes, even if the strobe drops.
        SERVE_I: begin
          if (m_ready) begin
            state <= IDLE;
            lg    <= 1'b0;
          end
        end
        SERVE_D: begin
          if (m_ready) begin
            state <= IDLE;
            lg    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign serve_i  = (state == SERVE_I);
  assign serve_d  = (state == SERVE_D);

  assign grant    = state;
  assign m_strobe = serve_i | serve_d;
  assign m_a      = serve_d ? d_a : i_a;
  assign m_rw     = serve_d & d_rw;
  assign m_din    = d_dout;
  assign i_din    = m_dout;
  assign d_din    = m_dout;
  assign i_ready  = serve_i & m_ready;
  assign d_ready  = serve_d & m_ready;

endmodule
